warp_lsu: RTL and testbench
===========================

# warp_lsu

Per-warp load/store unit sitting between operand fetch and register write-back. On a start pulse it latches every thread's `rs1`/`rs2` operands, the immediate and the execution mask. It then issues one memory request per enabled thread, serialised in ascending thread order over a single valid/ready memory port, and collects each thread's response into `lsu_out`, which feeds the warp register file's `LSU_OUT` write path.

## Interface
- `THREADS_PER_WARP`, 16, threads per warp; number of `rs1`/`rs2`/`lsu_out` lanes
- `DATA_WIDTH`, `` `DATA_WIDTH ``, width of data, address and operand words (`data_t`)
- `clk`  input  1  clock; all state changes on rising edge
- `reset`  input  1  asynchronous, active-low reset
- `start`  input  1  one-cycle pulse: begin memory phase of current instruction
- `thread_enable`  input  THREADS_PER_WARP  execution mask, sampled at `start`
- `decoded_mem_read_enable`  input  1  instruction is a load, sampled at `start`
- `decoded_mem_write_enable`  input  1  instruction is a store, sampled at `start`
- `decoded_immediate`  input  DATA_WIDTH  address offset, sampled at `start`
- `rs1`  input  DATA_WIDTH x THREADS_PER_WARP  per-thread base address
- `rs2`  input  DATA_WIDTH x THREADS_PER_WARP  per-thread store data
- `mem_req_valid`  output  1  request valid
- `mem_req_ready`  input  1  memory accepts request
- `mem_req_write`  output  1  1 = store, 0 = load
- `mem_req_addr`  output  DATA_WIDTH  request address
- `mem_req_wdata`  output  DATA_WIDTH  store data
- `mem_resp_valid`  input  1  response or write acknowledge, one per accepted request
- `mem_resp_rdata`  input  DATA_WIDTH  load data
- `lsu_out`  output  DATA_WIDTH x THREADS_PER_WARP  per-thread load result
- `lsu_busy`  output  1  high in any state other than IDLE
- `lsu_done`  output  1  one-cycle completion pulse

## Operation
- States:
  - IDLE: waits for `start`.
  - REQUEST: drives the current thread's request.
  - WAIT: awaits `mem_resp_valid`.
  - DONE: pulses `lsu_done`.
- IDLE + `start`:
  - Latch the mask, op, immediate and all `rs1`/`rs2` lanes.
  - If the op is neither read nor write, or the mask is zero, go to DONE.
  - Otherwise go to REQUEST with the pointer at the lowest enabled thread.
- Both read and write enables high: treated as a load; the write is ignored.
- REQUEST:
  - `mem_req_valid`=1, `mem_req_addr` = latched `rs1[p] + imm` mod 2^DATA_WIDTH, `mem_req_wdata` = latched `rs2[p]`.
  - On `valid && ready`, go to WAIT.
  - Address, data and write flag stay stable until accepted.
- WAIT:
  - On `mem_resp_valid`, a load writes `lsu_out[p] <= mem_resp_rdata`; a store leaves `lsu_out` unchanged.
  - The pointer advances to the next higher enabled thread and the state goes to REQUEST, or to DONE if none remain.
- DONE: `lsu_done`=1 for one cycle, then IDLE.
- `lsu_out` lanes of disabled threads hold their previous values.
- `start` while busy: ignored.
- `mem_resp_valid` outside WAIT: ignored.
- Input changes after `start`: no effect on the running operation.
- Reset value of all outputs is 0, including every `lsu_out` lane; the state returns to IDLE.
- Reset mid-operation: the in-flight request is abandoned and its late response is ignored.

## Timing
- `start` sampled at edge 0.
- `mem_req_valid` asserts from edge 1, registered.
- With ready=1 and response-next-cycle memory, each thread costs 2 cycles (REQUEST, WAIT).
- Next REQUEST follows the response edge directly.
- N enabled threads, zero-wait memory: `lsu_done` high in cycle 2N+1 after `start`.
- Empty mask or no-op: `lsu_done` in cycle 1.
- `lsu_out[p]` updates on the edge sampling `mem_resp_valid`; the value is valid once `lsu_done` is seen.
- No combinational path from any input to any output.

## Test plan
- Load, mask 0xFFFF, `rs1[i]`=4i, imm=0x100, memory returns addr^0xA5A5, no stalls -> addresses 0x100..0x13C in thread order; `lsu_out[i]`=(0x100+4i)^0xA5A5; `lsu_done` in cycle 33.
- Store, mask 0x0005, `rs2`={7,_,9} -> exactly two writes (thread0 data 7, thread2 data 9); `lsu_out` unchanged; done in cycle 5.
- Load with `mem_req_ready` low 3 cycles and a 4-cycle response delay -> request fields held stable while stalled; single capture per thread; `lsu_busy` high throughout.
- Mask 0, or both enables low -> no request issued; `lsu_done` pulses in cycle 1.
- `rs1`=0xFFFFFFF0 (DATA_WIDTH=32), imm=0x20 -> `mem_req_addr`=0x10; second `start` during the operation is ignored.
- Reset asserted in WAIT, late `mem_resp_valid` after release -> all outputs 0, IDLE, no capture.

Source files
------------

// File: rtl/warp_lsu.sv
// warp_lsu: per-warp load/store unit.
// Latches a warp's operands on start, then issues one memory request per enabled
// thread in ascending thread order over a single valid/ready port and collects the
// load results into lsu_out. All outputs are registered.

`timescale 1ns/1ps

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module warp_lsu #(
  parameter int unsigned THREADS_PER_WARP = 16,
  parameter int unsigned DATA_WIDTH       = `DATA_WIDTH
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             start,
  input  logic [THREADS_PER_WARP-1:0]                      thread_enable,
  input  logic                                             decoded_mem_read_enable,
  input  logic                                             decoded_mem_write_enable,
  input  logic [DATA_WIDTH-1:0]                            decoded_immediate,
  input  logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0]      rs1,
  input  logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0]      rs2,
  output logic                                             mem_req_valid,
  input  logic                                             mem_req_ready,
  output logic                                             mem_req_write,
  output logic [DATA_WIDTH-1:0]                            mem_req_addr,
  output logic [DATA_WIDTH-1:0]                            mem_req_wdata,
  input  logic                                             mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]                            mem_resp_rdata,
  output logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0]      lsu_out,
  output logic                                             lsu_busy,
  output logic                                             lsu_done
);

  localparam int unsigned PtrW = (THREADS_PER_WARP > 1) ? $clog2(THREADS_PER_WARP) : 1;

  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef enum logic [1:0] {
    StIdle,
    StRequest,
    StWait,
    StDone
  } state_e;

  state_e                                        state_q;
  logic [PtrW-1:0]                               ptr_q;
  logic [THREADS_PER_WARP-1:0]                   mask_q;
  logic                                          load_q;
  data_t                                         imm_q;
  logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0]   rs1_q;
  logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0]   rs2_q;
  logic                                          req_valid_q;
  logic                                          req_write_q;
  data_t                                         req_addr_q;
  data_t                                         req_wdata_q;
  logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0]   out_q;
  logic                                          busy_q;
  logic                                          done_q;

  logic            first_found;
  logic [PtrW-1:0] first_idx;
  logic            next_found;
  logic [PtrW-1:0] next_idx;
  logic            op_valid;
  data_t           start_addr;
  data_t           next_addr;

  // Thread selection: lowest enabled thread of the incoming mask, and the next
  // enabled thread above the current pointer in the latched mask.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = 0; i < int'(THREADS_PER_WARP); i++) begin
      if (!first_found && thread_enable[i]) begin
        first_found = 1'b1;
        first_idx   = PtrW'(i);
      end
      if (!next_found && mask_q[i] && (i > int'(ptr_q))) begin
        next_found = 1'b1;
        next_idx   = PtrW'(i);
      end
    end
  end

  // Request fields for the first thread (from live inputs) and the next thread
  // (from latched operands); addresses wrap modulo 2^DATA_WIDTH.
  always_comb begin
    op_valid   = decoded_mem_read_enable | decoded_mem_write_enable;
    start_addr = rs1[first_idx] + decoded_immediate;
    next_addr  = rs1_q[next_idx] + imm_q;
  end

  // Main FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      mask_q      <= '0;
      load_q      <= 1'b0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      out_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            mask_q      <= thread_enable;
            load_q      <= decoded_mem_read_enable;
            // A load takes priority when both enables are set.
            req_write_q <= decoded_mem_write_enable & ~decoded_mem_read_enable;
            imm_q       <= decoded_immediate;
            rs1_q       <= rs1;
            rs2_q       <= rs2;
            busy_q      <= 1'b1;
            if (op_valid && first_found) begin
              state_q     <= StRequest;
              ptr_q       <= first_idx;
              req_valid_q <= 1'b1;
              req_addr_q  <= start_addr;
              req_wdata_q <= rs2[first_idx];
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StRequest: begin
          // Fields are held untouched until the memory accepts.
          if (mem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= StWait;
          end
        end
        StWait: begin
          if (mem_resp_valid) begin
            if (load_q) begin
              out_q[ptr_q] <= mem_resp_rdata;
            end
            if (next_found) begin
              state_q     <= StRequest;
              ptr_q       <= next_idx;
              req_valid_q <= 1'b1;
              req_addr_q  <= next_addr;
              req_wdata_q <= rs2_q[next_idx];
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign mem_req_valid = req_valid_q;
  assign mem_req_write = req_write_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wdata = req_wdata_q;
  assign lsu_out       = out_q;
  assign lsu_busy      = busy_q;
  assign lsu_done      = done_q;

endmodule

// File: tb/tb_warp_lsu.sv
// Scoreboard bench for warp_lsu: the driver pushes the expected request stream and
// load results at each start; a negedge monitor checks every presented request.

`timescale 1ns/1ps

module tb_warp_lsu;

  localparam int T  = 16;
  localparam int DW = 32;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    start = 1'b0;
  logic [T-1:0]            thread_enable = '0;
  logic                    rd_en = 1'b0;
  logic                    wr_en = 1'b0;
  logic [DW-1:0]           imm_in = '0;
  logic [T-1:0][DW-1:0]    rs1 = '0;
  logic [T-1:0][DW-1:0]    rs2 = '0;
  logic                    mem_req_valid;
  logic                    mem_req_ready = 1'b0;
  logic                    mem_req_write;
  logic [DW-1:0]           mem_req_addr;
  logic [DW-1:0]           mem_req_wdata;
  logic                    mem_resp_valid = 1'b0;
  logic [DW-1:0]           mem_resp_rdata = '0;
  logic [T-1:0][DW-1:0]    lsu_out;
  logic                    lsu_busy;
  logic                    lsu_done;

  always #5 clk = ~clk;

  warp_lsu #(
    .THREADS_PER_WARP(T),
    .DATA_WIDTH      (DW)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .start                   (start),
    .thread_enable           (thread_enable),
    .decoded_mem_read_enable (rd_en),
    .decoded_mem_write_enable(wr_en),
    .decoded_immediate       (imm_in),
    .rs1                     (rs1),
    .rs2                     (rs2),
    .mem_req_valid           (mem_req_valid),
    .mem_req_ready           (mem_req_ready),
    .mem_req_write           (mem_req_write),
    .mem_req_addr            (mem_req_addr),
    .mem_req_wdata           (mem_req_wdata),
    .mem_resp_valid          (mem_resp_valid),
    .mem_resp_rdata          (mem_resp_rdata),
    .lsu_out                 (lsu_out),
    .lsu_busy                (lsu_busy),
    .lsu_done                (lsu_done)
  );

  typedef struct packed {
    logic          write;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  req_t          exp_q[$];
  logic [DW-1:0] exp_out[T];
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] key = 32'h0000A5A5;

  // Memory model knobs: ready after stall_n valid cycles, response resp_delay cycles later.
  int            stall_n = 0;
  int            resp_delay = 1;
  int            vcount = 0;
  bit            resp_armed = 1'b0;
  int            resp_timer = 0;
  logic [DW-1:0] resp_data = '0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: drives ready/response just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mem_req_valid) vcount++;
      else vcount = 0;
      mem_req_ready  = (vcount > stall_n);
      mem_resp_valid = 1'b0;
      if (resp_armed) begin
        if (resp_timer <= 1) begin
          mem_resp_valid = 1'b1;
          mem_resp_rdata = resp_data;
          resp_armed     = 1'b0;
        end else begin
          resp_timer--;
        end
      end
    end
  end

  // Monitor: every presented request must match the scoreboard head.
  always @(negedge clk) begin
    if (reset && mem_req_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: got request addr 0x%0h, required no request", mem_req_addr);
      end else begin
        check("req_addr", mem_req_addr, exp_q[0].addr);
        check("req_write", DW'(mem_req_write), DW'(exp_q[0].write));
        check("req_wdata", mem_req_wdata, exp_q[0].wdata);
        if (mem_req_ready) begin
          void'(exp_q.pop_front());
          resp_armed = 1'b1;
          resp_timer = resp_delay;
          resp_data  = mem_req_addr ^ key;
        end
      end
    end
  end

  task automatic scramble_inputs();
    thread_enable = T'($urandom);
    rd_en         = 1'($urandom);
    wr_en         = 1'($urandom);
    imm_in        = $urandom;
    for (int i = 0; i < T; i++) begin
      rs1[i] = $urandom;
      rs2[i] = $urandom;
    end
  endtask

  task automatic run_op(input logic [T-1:0] mask, input bit rd, input bit wr,
                        input logic [DW-1:0] imm, input int stall, input int delay,
                        input bit second_start);
    int  n;
    int  cyc;
    int  exp_cyc;
    bit  seen;
    n          = 0;
    cyc        = 0;
    seen       = 1'b0;
    stall_n    = stall;
    resp_delay = delay;
    @(posedge clk);
    #1;
    thread_enable = mask;
    rd_en         = rd;
    wr_en         = wr;
    imm_in        = imm;
    start         = 1'b1;
    for (int i = 0; i < T; i++) begin
      if (mask[i] && (rd || wr)) begin
        n++;
        exp_q.push_back('{write: !rd, addr: rs1[i] + imm, wdata: rs2[i]});
        if (rd) exp_out[i] = (rs1[i] + imm) ^ key;
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble_inputs();
    while (!seen && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (second_start) begin
        if (cyc == 2) start = 1'b1;
        if (cyc == 3) start = 1'b0;
      end
      check("busy_during_op", DW'(lsu_busy), 32'd1);
      if (lsu_done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no lsu_done in %0d cycles, required a pulse", cyc);
    end else begin
      exp_cyc = (n == 0) ? 1 : n * (stall + 1 + delay) + 1;
      check("done_cycle", DW'(cyc), DW'(exp_cyc));
    end
    @(negedge clk);
    check("done_pulse_len", DW'(lsu_done), 32'd0);
    check("busy_after", DW'(lsu_busy), 32'd0);
    check("valid_after", DW'(mem_req_valid), 32'd0);
    check("reqs_left", DW'(exp_q.size()), 32'd0);
    exp_q.delete();
    for (int i = 0; i < T; i++) check($sformatf("lsu_out[%0d]", i), lsu_out[i], exp_out[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    for (int i = 0; i < T; i++) exp_out[i] = '0;

    // Reset values.
    #12;
    check("rst_valid", DW'(mem_req_valid), 32'd0);
    check("rst_write", DW'(mem_req_write), 32'd0);
    check("rst_addr", mem_req_addr, 32'd0);
    check("rst_wdata", mem_req_wdata, 32'd0);
    check("rst_busy", DW'(lsu_busy), 32'd0);
    check("rst_done", DW'(lsu_done), 32'd0);
    for (int i = 0; i < T; i++) check("rst_lsu_out", lsu_out[i], 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Full-warp load, zero-wait memory.
    for (int i = 0; i < T; i++) rs1[i] = DW'(4 * i);
    run_op(16'hFFFF, 1'b1, 1'b0, 32'h100, 0, 1, 1'b0);

    // Sparse store: lsu_out must not change.
    for (int i = 0; i < T; i++) rs2[i] = $urandom;
    rs2[0] = 32'd7;
    rs2[2] = 32'd9;
    run_op(16'h0005, 1'b0, 1'b1, 32'h0, 0, 1, 1'b0);

    // Load with ready stalls and slow responses.
    scramble_inputs();
    run_op(16'h8421, 1'b1, 1'b0, 32'h40, 3, 4, 1'b0);

    // Empty mask, then no-op instruction.
    run_op(16'h0000, 1'b1, 1'b0, 32'h0, 0, 1, 1'b0);
    run_op(16'hFFFF, 1'b0, 1'b0, 32'h0, 0, 1, 1'b0);

    // Address wrap plus an ignored second start.
    for (int i = 0; i < T; i++) rs1[i] = 32'hFFFF_FFF0;
    run_op(16'hFFFF, 1'b1, 1'b0, 32'h20, 0, 1, 1'b1);

    // Both enables: behaves as a load.
    scramble_inputs();
    run_op(16'h00F0, 1'b1, 1'b1, 32'h8, 0, 2, 1'b0);

    // Randomised operations.
    for (int k = 0; k < 24; k++) begin
      logic [T-1:0] m;
      key = $urandom;
      scramble_inputs();
      m = (k % 3 == 0) ? (T'($urandom) & T'($urandom) & T'($urandom)) : T'($urandom);
      run_op(m, 1'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 2)),
             int'($urandom_range(1, 3)), 1'b0);
    end

    // Reset while waiting for a response; the late response must be ignored.
    scramble_inputs();
    stall_n    = 0;
    resp_delay = 6;
    @(posedge clk);
    #1;
    thread_enable = 16'h0002;
    rd_en         = 1'b1;
    wr_en         = 1'b0;
    start         = 1'b1;
    exp_q.push_back('{write: 1'b0, addr: rs1[1] + imm_in, wdata: rs2[1]});
    @(posedge clk);
    #1;
    start = 1'b0;
    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      @(negedge clk);
      #2;
      w++;
    end
    check("rst_test_req_accepted", DW'(exp_q.size()), 32'd0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < T; i++) exp_out[i] = '0;
    #1;
    check("midrst_busy", DW'(lsu_busy), 32'd0);
    check("midrst_valid", DW'(mem_req_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("late_resp_done", DW'(lsu_done), 32'd0);
      check("late_resp_busy", DW'(lsu_busy), 32'd0);
      check("late_resp_valid", DW'(mem_req_valid), 32'd0);
    end
    for (int i = 0; i < T; i++) check($sformatf("late_resp_lsu_out[%0d]", i), lsu_out[i], exp_out[i]);
    check("late_resp_write", DW'(mem_req_write), 32'd0);
    check("late_resp_addr", mem_req_addr, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
